// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI frame receiver.
//   state_t         : receiver FSM states
//   SAMPLE_ON_FALL/SAMPLE_ON_RISE : values of the SAMPLE_RISE parameter
//   SYNC_* indices  : bit positions of the synchronised inputs in the top
package spi_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_OVERFLOW
  } state_t;

  localparam int SAMPLE_ON_FALL = 0;  // modes 1/2
  localparam int SAMPLE_ON_RISE = 1;  // modes 0/3

  localparam int SYNC_CLK = 0;
  localparam int SYNC_SDI = 1;
  localparam int SYNC_NCS = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser followed by an edge detector.
//   clk_i   : destination clock
//   rst_i   : asynchronous active-high reset, loads RESET_VAL into every flop
//   d_i     : asynchronous input
//   level_o : synchronised level
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
//   fall_o  : one-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: a frame (n_cs low) carries HDR_BYTES header bytes
// that form the settings word, followed by payload bytes that are scattered
// over NUM_DEVICES RAMs of DEV_DEPTH bytes each.
//   clk_sys   : system clock, all logic runs here
//   reset     : asynchronous active-high reset
//   clk_spi   : SPI clock, oversampled (clk_sys >= 4x clk_spi)
//   sdi       : serial data, MSB first
//   n_cs      : active-low frame select
//   d_out     : last payload byte, held until the next strobe
//   write_en  : one-hot write strobe, one clk_sys cycle per payload byte
//   waddr     : device-local byte address for d_out
//   settings  : last complete header, first byte in the MSBs
//   send      : one-cycle pulse when a frame that reached payload ends
//   frame_err : sticky error flag, cleared at the next frame start
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int NUM_DEVICES = 20,
  parameter int DEV_DEPTH   = 512,
  parameter int HDR_BYTES   = 2,
  parameter int SAMPLE_RISE = 1
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         clk_spi,
  input  logic                         sdi,
  input  logic                         n_cs,
  output logic [7:0]                   d_out,
  output logic [NUM_DEVICES-1:0]       write_en,
  output logic [$clog2(DEV_DEPTH)-1:0] waddr,
  output logic [8*HDR_BYTES-1:0]       settings,
  output logic                         send,
  output logic                         frame_err
);

  localparam int AW = $clog2(DEV_DEPTH);
  localparam int DW = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  localparam int HW = 8 * HDR_BYTES;
  // Idle levels: n_cs high, sdi and clk_spi low.
  localparam logic [2:0] SYNC_IDLE = 3'b100;

  logic [2:0] raw_in;
  logic [2:0] sync_level;
  logic [2:0] sync_rise;
  logic [2:0] sync_fall;

  assign raw_in = {n_cs, sdi, clk_spi};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      spi_sync_edge #(
        .RESET_VAL(SYNC_IDLE[gi])
      ) u_sync (
        .clk_i  (clk_sys),
        .rst_i  (reset),
        .d_i    (raw_in[gi]),
        .level_o(sync_level[gi]),
        .rise_o (sync_rise[gi]),
        .fall_o (sync_fall[gi])
      );
    end
  endgenerate

  logic sample_pulse;
  logic sdi_s;
  logic ncs_s;
  logic ncs_rise;
  logic ncs_fall;

  assign sample_pulse = (SAMPLE_RISE == SAMPLE_ON_RISE) ? sync_rise[SYNC_CLK]
                                                        : sync_fall[SYNC_CLK];
  assign sdi_s    = sync_level[SYNC_SDI];
  assign ncs_s    = sync_level[SYNC_NCS];
  assign ncs_rise = sync_rise[SYNC_NCS];
  assign ncs_fall = sync_fall[SYNC_NCS];

  state_t                 state_q;
  logic [7:0]             shift_q;
  logic [7:0]             shift_d;
  logic [2:0]             bit_cnt_q;
  logic [1:0]             byte_cnt_q;
  logic [HW-1:0]          hdr_q;
  logic [HW-1:0]          hdr_d;
  logic [HW+7:0]          hdr_cat;
  logic [AW-1:0]          addr_q;
  logic [DW-1:0]          dev_q;
  logic [NUM_DEVICES-1:0] dev_onehot;
  logic [1:0]             flush_q;
  logic                   armed_q;

  logic [7:0]             d_out_q;
  logic [NUM_DEVICES-1:0] write_en_q;
  logic [AW-1:0]          waddr_q;
  logic [HW-1:0]          settings_q;
  logic                   send_q;
  logic                   frame_err_q;

  // Byte including the bit being sampled this cycle.
  assign shift_d = {shift_q[6:0], sdi_s};
  assign hdr_cat = {hdr_q, shift_d};
  assign hdr_d   = hdr_cat[HW-1:0];

  generate
    for (gi = 0; gi < NUM_DEVICES; gi++) begin : g_onehot
      assign dev_onehot[gi] = (dev_q == DW'(gi));
    end
  endgenerate

  // The synchronisers reset to "n_cs high", so a frame already in progress
  // when reset releases shows up as a fake falling edge. armed_q only sets
  // once the synchroniser pipeline has flushed and n_cs is genuinely high,
  // so such a frame is skipped until n_cs rises and falls again.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      hdr_q       <= '0;
      addr_q      <= '0;
      dev_q       <= '0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      d_out_q     <= '0;
      write_en_q  <= '0;
      waddr_q     <= '0;
      settings_q  <= '0;
      send_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      send_q     <= 1'b0;
      write_en_q <= '0;

      if (flush_q != 2'd3) begin
        flush_q <= flush_q + 2'd1;
      end else if (ncs_s) begin
        armed_q <= 1'b1;
      end

      if (ncs_fall && armed_q) begin
        state_q     <= ST_HEADER;
        shift_q     <= '0;
        bit_cnt_q   <= '0;
        byte_cnt_q  <= '0;
        hdr_q       <= '0;
        addr_q      <= '0;
        dev_q       <= '0;
        frame_err_q <= 1'b0;
      end else if (ncs_rise) begin
        case (state_q)
          ST_HEADER: frame_err_q <= 1'b1;
          ST_PAYLOAD, ST_OVERFLOW: begin
            send_q <= 1'b1;
            if (bit_cnt_q != 3'd0) begin
              frame_err_q <= 1'b1;
            end
          end
          default: ;
        endcase
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
      end else if (sample_pulse && !ncs_s && state_q != ST_IDLE) begin
        shift_q   <= shift_d;
        bit_cnt_q <= bit_cnt_q + 3'd1;  // wraps to 0 on the 8th bit
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            ST_HEADER: begin
              hdr_q <= hdr_d;
              if (byte_cnt_q == 2'(HDR_BYTES - 1)) begin
                settings_q <= hdr_d;
                state_q    <= ST_PAYLOAD;
              end else begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
              end
            end
            ST_PAYLOAD: begin
              d_out_q    <= shift_d;
              waddr_q    <= addr_q;
              write_en_q <= dev_onehot;
              // Address wraps per device; the last byte of the last device
              // exhausts the RAM space.
              if (addr_q == AW'(DEV_DEPTH - 1)) begin
                addr_q <= '0;
                if (dev_q == DW'(NUM_DEVICES - 1)) begin
                  state_q <= ST_OVERFLOW;
                end else begin
                  dev_q <= dev_q + 1'b1;
                end
              end else begin
                addr_q <= addr_q + 1'b1;
              end
            end
            default: frame_err_q <= 1'b1;  // byte discarded in OVERFLOW
          endcase
        end
      end
    end
  end

  assign d_out     = d_out_q;
  assign write_en  = write_en_q;
  assign waddr     = waddr_q;
  assign settings  = settings_q;
  assign send      = send_q;
  assign frame_err = frame_err_q;

  logic unused_sync;
  assign unused_sync = ^{sync_level[SYNC_CLK], sync_rise[SYNC_SDI],
                         sync_fall[SYNC_SDI], hdr_cat[HW+7:HW], shift_q[7]};

endmodule

// File: tb/tb_spi_frame_rx.sv
`timescale 1ns/1ps
module tb_spi_frame_rx;

  localparam real HALF = 5.0;  // clk_spi 100 MHz

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       clk_spi = 1'b0;
  logic       sdi     = 1'b0;
  logic [2:0] n_cs    = 3'b111;
  bit         mode1   = 1'b0;

  always #2 clk_sys = ~clk_sys;  // 250 MHz

  // dut0: defaults
  logic [7:0]  d_out0;
  logic [19:0] we0;
  logic [8:0]  waddr0;
  logic [15:0] settings0;
  logic        send0, ferr0;
  // dut1: 2 devices x 4 bytes
  logic [7:0]  d_out1;
  logic [1:0]  we1;
  logic [1:0]  waddr1;
  logic [15:0] settings1;
  logic        send1, ferr1;
  // dut2: sample on falling edge
  logic [7:0]  d_out2;
  logic [19:0] we2;
  logic [8:0]  waddr2;
  logic [15:0] settings2;
  logic        send2, ferr2;

  spi_frame_rx dut0 (
    .clk_sys(clk_sys), .reset(reset), .clk_spi(clk_spi), .sdi(sdi), .n_cs(n_cs[0]),
    .d_out(d_out0), .write_en(we0), .waddr(waddr0), .settings(settings0),
    .send(send0), .frame_err(ferr0));

  spi_frame_rx #(.NUM_DEVICES(2), .DEV_DEPTH(4)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .clk_spi(clk_spi), .sdi(sdi), .n_cs(n_cs[1]),
    .d_out(d_out1), .write_en(we1), .waddr(waddr1), .settings(settings1),
    .send(send1), .frame_err(ferr1));

  spi_frame_rx #(.SAMPLE_RISE(0)) dut2 (
    .clk_sys(clk_sys), .reset(reset), .clk_spi(clk_spi), .sdi(sdi), .n_cs(n_cs[2]),
    .d_out(d_out2), .write_en(we2), .waddr(waddr2), .settings(settings2),
    .send(send2), .frame_err(ferr2));

  typedef struct packed {
    logic [31:0] we;
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t wr0[$], wr1[$], wr2[$];
  int  send_cnt0 = 0, send_cnt1 = 0, send_cnt2 = 0;

  always @(negedge clk_sys) begin
    if (we0 != '0) wr0.push_back({32'(we0), 32'(waddr0), d_out0});
    if (we1 != '0) wr1.push_back({32'(we1), 32'(waddr1), d_out1});
    if (we2 != '0) wr2.push_back({32'(we2), 32'(waddr2), d_out2});
    if (send0) send_cnt0++;
    if (send1) send_cnt1++;
    if (send2) send_cnt2++;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  pay_q[$];
  wr_t         exp_q[$];
  logic [15:0] last_hdr = 16'h0000;

  // Payload byte k lands in device k/depth at address k%depth while the
  // RAM space lasts; later bytes produce no write.
  task automatic build_exp(input int depth, input int ndev);
    exp_q.delete();
    for (int k = 0; k < pay_q.size(); k++)
      if (k < depth * ndev)
        exp_q.push_back({32'(1) << (k / depth), 32'(k % depth), pay_q[k]});
  endtask

  task automatic make_frame(input logic [15:0] hdr, input int n_pay, input bit rnd);
    tx_q.delete();
    pay_q.delete();
    tx_q.push_back(hdr[15:8]);
    tx_q.push_back(hdr[7:0]);
    for (int i = 0; i < n_pay; i++) pay_q.push_back(rnd ? 8'($urandom) : 8'(i));
    foreach (pay_q[i]) tx_q.push_back(pay_q[i]);
  endtask

  task automatic spi_bit(input logic b);
    if (!mode1) begin
      sdi = b; #(HALF); clk_spi = 1'b1; #(HALF); clk_spi = 1'b0;
    end else begin
      clk_spi = 1'b1; sdi = b; #(HALF); clk_spi = 1'b0; #(HALF);
    end
  endtask

  task automatic spi_begin(input int sel);
    @(negedge clk_sys);
    #1.5;  // keep SPI edges off the clk_sys edges
    n_cs[sel] = 1'b0;
    #(4 * HALF);
  endtask

  task automatic spi_bytes();
    foreach (tx_q[i])
      for (int b = 7; b >= 0; b--) spi_bit(tx_q[i][b]);
  endtask

  task automatic spi_bits(input int n);
    for (int i = 0; i < n; i++) spi_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic spi_end(input int sel);
    #(4 * HALF);
    n_cs[sel] = 1'b1;
    sdi = 1'b0;
    #(12 * HALF);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk_sys);
    checks++; if (d_out0 !== 8'h00) begin errors++; $display("FAIL reset_d_out got %0h exp 0", d_out0); end
    checks++; if (we0 !== 20'h0) begin errors++; $display("FAIL reset_write_en got %0h exp 0", we0); end
    checks++; if (waddr0 !== 9'h0) begin errors++; $display("FAIL reset_waddr got %0h exp 0", waddr0); end
    checks++; if (settings0 !== 16'h0) begin errors++; $display("FAIL reset_settings got %0h exp 0", settings0); end
    checks++; if (send0 !== 1'b0) begin errors++; $display("FAIL reset_send got %0b exp 0", send0); end
    checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0b exp 0", ferr0); end
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);
    checks++; if (send_cnt0 !== 0 || we0 !== 20'h0) begin errors++; $display("FAIL reset_idle got send_cnt %0d we %0h exp 0 0", send_cnt0, we0); end
  endtask

  task automatic test_full_frame();
    int b0 = wr0.size();
    int s0 = send_cnt0;
    make_frame(16'hA53C, 257, 1'b0);
    build_exp(512, 20);
    spi_begin(0); spi_bytes(); spi_end(0);
    last_hdr = 16'hA53C;
    checks++; if (settings0 !== 16'hA53C) begin errors++; $display("FAIL full_settings got %0h exp a53c", settings0); end
    checks++; if (wr0.size() - b0 != 257) begin errors++; $display("FAIL full_nwrites got %0d exp 257", wr0.size() - b0); end
    foreach (exp_q[k]) if (b0 + k < wr0.size()) begin
      checks++; if (wr0[b0 + k] !== exp_q[k]) begin errors++; $display("FAIL full_write%0d got %h exp %h", k, wr0[b0 + k], exp_q[k]); end
    end
    if (b0 + 256 < wr0.size()) begin
      checks++; if (wr0[b0 + 256] !== {32'h1, 32'd256, 8'h00}) begin errors++; $display("FAIL full_byte256 got %h exp dev0 addr 256 data 0", wr0[b0 + 256]); end
    end
    checks++; if (send_cnt0 - s0 != 1) begin errors++; $display("FAIL full_send got %0d exp 1", send_cnt0 - s0); end
    checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL full_frame_err got %0b exp 0", ferr0); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      int b0 = wr0.size();
      int s0 = send_cnt0;
      logic [15:0] hdr = 16'($urandom);
      make_frame(hdr, $urandom_range(1, 40), 1'b1);
      build_exp(512, 20);
      spi_begin(0); spi_bytes(); spi_end(0);
      last_hdr = hdr;
      checks++; if (settings0 !== hdr) begin errors++; $display("FAIL rand%0d_settings got %0h exp %0h", f, settings0, hdr); end
      checks++; if (wr0.size() - b0 != exp_q.size()) begin errors++; $display("FAIL rand%0d_nwrites got %0d exp %0d", f, wr0.size() - b0, exp_q.size()); end
      foreach (exp_q[k]) if (b0 + k < wr0.size()) begin
        checks++; if (wr0[b0 + k] !== exp_q[k]) begin errors++; $display("FAIL rand%0d_write%0d got %h exp %h", f, k, wr0[b0 + k], exp_q[k]); end
      end
      checks++; if (send_cnt0 - s0 != 1 || ferr0 !== 1'b0) begin errors++; $display("FAIL rand%0d_end got send %0d err %0b exp 1 0", f, send_cnt0 - s0, ferr0); end
    end
  endtask

  task automatic test_overflow();
    int b0 = wr1.size();
    int s0 = send_cnt1;
    logic [15:0] hdr = 16'($urandom);
    make_frame(hdr, 11, 1'b1);
    build_exp(4, 2);
    spi_begin(1); spi_bytes(); spi_end(1);
    checks++; if (settings1 !== hdr) begin errors++; $display("FAIL ovf_settings got %0h exp %0h", settings1, hdr); end
    checks++; if (wr1.size() - b0 != 8) begin errors++; $display("FAIL ovf_nwrites got %0d exp 8", wr1.size() - b0); end
    foreach (exp_q[k]) if (b0 + k < wr1.size()) begin
      checks++; if (wr1[b0 + k] !== exp_q[k]) begin errors++; $display("FAIL ovf_write%0d got %h exp %h", k, wr1[b0 + k], exp_q[k]); end
    end
    checks++; if (ferr1 !== 1'b1) begin errors++; $display("FAIL ovf_frame_err got %0b exp 1", ferr1); end
    checks++; if (send_cnt1 - s0 != 1) begin errors++; $display("FAIL ovf_send got %0d exp 1", send_cnt1 - s0); end
  endtask

  task automatic test_short_header();
    int b0 = wr0.size();
    int s0 = send_cnt0;
    logic [15:0] hdr;
    tx_q.delete();
    tx_q.push_back(8'($urandom));
    spi_begin(0); spi_bytes(); spi_end(0);
    checks++; if (settings0 !== last_hdr) begin errors++; $display("FAIL short_settings got %0h exp %0h", settings0, last_hdr); end
    checks++; if (send_cnt0 - s0 != 0) begin errors++; $display("FAIL short_send got %0d exp 0", send_cnt0 - s0); end
    checks++; if (ferr0 !== 1'b1) begin errors++; $display("FAIL short_frame_err got %0b exp 1", ferr0); end
    checks++; if (wr0.size() - b0 != 0) begin errors++; $display("FAIL short_nwrites got %0d exp 0", wr0.size() - b0); end
    hdr = 16'($urandom);
    make_frame(hdr, 3, 1'b1);
    build_exp(512, 20);
    b0 = wr0.size();
    spi_begin(0);
    checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL short_err_clear got %0b exp 0", ferr0); end
    spi_bytes(); spi_end(0);
    last_hdr = hdr;
    checks++; if (settings0 !== hdr) begin errors++; $display("FAIL short_next_settings got %0h exp %0h", settings0, hdr); end
    checks++; if (wr0.size() - b0 != 3) begin errors++; $display("FAIL short_next_nwrites got %0d exp 3", wr0.size() - b0); end
  endtask

  task automatic test_partial_byte();
    int b0 = wr0.size();
    int s0 = send_cnt0;
    logic [15:0] hdr = 16'($urandom);
    make_frame(hdr, 3, 1'b1);
    build_exp(512, 20);
    spi_begin(0); spi_bytes(); spi_bits(5); spi_end(0);
    last_hdr = hdr;
    checks++; if (wr0.size() - b0 != 3) begin errors++; $display("FAIL partial_nwrites got %0d exp 3", wr0.size() - b0); end
    foreach (exp_q[k]) if (b0 + k < wr0.size()) begin
      checks++; if (wr0[b0 + k] !== exp_q[k]) begin errors++; $display("FAIL partial_write%0d got %h exp %h", k, wr0[b0 + k], exp_q[k]); end
    end
    checks++; if (send_cnt0 - s0 != 1) begin errors++; $display("FAIL partial_send got %0d exp 1", send_cnt0 - s0); end
    checks++; if (ferr0 !== 1'b1) begin errors++; $display("FAIL partial_frame_err got %0b exp 1", ferr0); end
  endtask

  task automatic test_reset_mid_frame();
    int b0;
    int s0;
    logic [15:0] hdr = 16'($urandom);
    make_frame(hdr, 2, 1'b1);
    spi_begin(0); spi_bytes();
    #(4 * HALF); reset = 1'b1; #(4 * HALF); reset = 1'b0; #(4 * HALF);
    last_hdr = 16'h0000;
    b0 = wr0.size();
    s0 = send_cnt0;
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
    spi_bytes();
    checks++; if (wr0.size() - b0 != 0) begin errors++; $display("FAIL rst_mid_nwrites got %0d exp 0", wr0.size() - b0); end
    checks++; if ({d_out0, waddr0, we0} !== '0) begin errors++; $display("FAIL rst_mid_data got d_out %0h waddr %0h we %0h exp 0", d_out0, waddr0, we0); end
    checks++; if (settings0 !== 16'h0 || ferr0 !== 1'b0) begin errors++; $display("FAIL rst_mid_status got settings %0h err %0b exp 0 0", settings0, ferr0); end
    spi_end(0);
    checks++; if (send_cnt0 - s0 != 0 || wr0.size() - b0 != 0) begin errors++; $display("FAIL rst_mid_end got send %0d writes %0d exp 0 0", send_cnt0 - s0, wr0.size() - b0); end
    hdr = 16'($urandom);
    make_frame(hdr, 6, 1'b1);
    build_exp(512, 20);
    b0 = wr0.size();
    s0 = send_cnt0;
    spi_begin(0); spi_bytes(); spi_end(0);
    last_hdr = hdr;
    checks++; if (settings0 !== hdr) begin errors++; $display("FAIL rst_next_settings got %0h exp %0h", settings0, hdr); end
    checks++; if (wr0.size() - b0 != exp_q.size()) begin errors++; $display("FAIL rst_next_nwrites got %0d exp %0d", wr0.size() - b0, exp_q.size()); end
    foreach (exp_q[k]) if (b0 + k < wr0.size()) begin
      checks++; if (wr0[b0 + k] !== exp_q[k]) begin errors++; $display("FAIL rst_next_write%0d got %h exp %h", k, wr0[b0 + k], exp_q[k]); end
    end
    checks++; if (send_cnt0 - s0 != 1 || ferr0 !== 1'b0) begin errors++; $display("FAIL rst_next_end got send %0d err %0b exp 1 0", send_cnt0 - s0, ferr0); end
  endtask

  task automatic test_mode1();
    int b0 = wr2.size();
    int s0 = send_cnt2;
    mode1 = 1'b1;
    make_frame(16'h817E, 5, 1'b1);
    build_exp(512, 20);
    spi_begin(2); spi_bytes(); spi_end(2);
    mode1 = 1'b0;
    checks++; if (settings2 !== 16'h817E) begin errors++; $display("FAIL mode1_settings got %0h exp 817e", settings2); end
    checks++; if (wr2.size() - b0 != 5) begin errors++; $display("FAIL mode1_nwrites got %0d exp 5", wr2.size() - b0); end
    foreach (exp_q[k]) if (b0 + k < wr2.size()) begin
      checks++; if (wr2[b0 + k] !== exp_q[k]) begin errors++; $display("FAIL mode1_write%0d got %h exp %h", k, wr2[b0 + k], exp_q[k]); end
    end
    checks++; if (send_cnt2 - s0 != 1 || ferr2 !== 1'b0) begin errors++; $display("FAIL mode1_end got send %0d err %0b exp 1 0", send_cnt2 - s0, ferr2); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_frames();
    test_overflow();
    test_short_header();
    test_partial_byte();
    test_reset_mid_frame();
    test_mode1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
